// File: rtl/tinycpu_pkg.sv
// Shared tinycpu constants: RAM geometry defaults and the stream master FSM encoding.
package tinycpu_pkg;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 12;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_HI     = 3'd1;
  localparam logic [2:0] ST_WR_LO     = 3'd2;
  localparam logic [2:0] ST_WR_COMMIT = 3'd3;
  localparam logic [2:0] ST_RD_ADDR   = 3'd4;
  localparam logic [2:0] ST_RD_CAP    = 3'd5;
  localparam logic [2:0] ST_RD_HI     = 3'd6;
  localparam logic [2:0] ST_RD_LO     = 3'd7;

  function automatic logic is_read_byte_state(input logic [2:0] st);
    return (st == ST_RD_HI) || (st == ST_RD_LO);
  endfunction

endpackage

// File: rtl/byte_word_pack.sv
// Word register that assembles two bytes (high first) into a word, or splits a
// captured word back into bytes with a hi/lo select.
module byte_word_pack #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic              load_word,
  input  logic [7:0]        byte_in,
  input  logic [DWIDTH-1:0] word_in,
  input  logic              sel_lo,
  output logic [DWIDTH-1:0] word,
  output logic [7:0]        byte_out
);

  logic [DWIDTH-1:0] word_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= '0;
    end else if (load_word) begin
      word_r <= word_in;
    end else begin
      if (load_hi) word_r[DWIDTH-1 -: 8] <= byte_in;
      if (load_lo) word_r[7:0]           <= byte_in;
    end
  end

  assign word     = word_r;
  assign byte_out = sel_lo ? word_r[7:0] : word_r[DWIDTH-1 -: 8];

endmodule

// File: rtl/ram_stream_master.sv
// Host byte stream to tinycpu RAM bridge: block writes and block reads, one word
// (two bytes, high first) at a time.
module ram_stream_master
  import tinycpu_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH-1:0] cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q,
  output logic [2:0]        fsm_state
);

  // All handshakes: a transfer happens on a posedge where valid and ready are
  // both high; ready never looks at valid, and out_valid/out_data hold until taken.

  logic [2:0]        state;
  logic [AWIDTH-1:0] addr_r;
  logic [AWIDTH-1:0] cnt_r;
  logic              done_r;
  logic [DWIDTH-1:0] word;

  logic cmd_fire;
  logic in_fire;
  logic out_fire;
  logic last_word;

  assign cmd_ready = !reset && (state == ST_IDLE);
  assign in_ready  = !reset && ((state == ST_WR_HI) || (state == ST_WR_LO));
  assign out_valid = !reset && is_read_byte_state(state);
  assign busy      = !reset && (state != ST_IDLE);
  assign done      = !reset && done_r;
  // Gated so a reset edge can never turn into a RAM write.
  assign ram_load  = !reset && (state == ST_WR_COMMIT);
  assign ram_addr  = addr_r;
  assign ram_d     = word;
  assign fsm_state = state;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (cnt_r == '0);

  byte_word_pack #(.DWIDTH(DWIDTH)) u_pack (
    .clk       (clk),
    .reset     (reset),
    .load_hi   (in_fire && (state == ST_WR_HI)),
    .load_lo   (in_fire && (state == ST_WR_LO)),
    .load_word (state == ST_RD_CAP),
    .byte_in   (in_data),
    .word_in   (ram_q),
    .sel_lo    (state == ST_RD_LO),
    .word      (word),
    .byte_out  (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr_r <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr_r <= cmd_addr;
            cnt_r  <= cmd_len;
            state  <= cmd_write ? ST_WR_HI : ST_RD_ADDR;
          end
        end
        ST_WR_HI: if (in_fire) state <= ST_WR_LO;
        ST_WR_LO: if (in_fire) state <= ST_WR_COMMIT;
        ST_WR_COMMIT: begin
          if (last_word) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            addr_r <= addr_r + 1'b1;
            cnt_r  <= cnt_r - 1'b1;
            state  <= ST_WR_HI;
          end
        end
        // RAM registers q on the edge leaving RD_ADDR; it is captured leaving RD_CAP.
        ST_RD_ADDR: state <= ST_RD_CAP;
        ST_RD_CAP:  state <= ST_RD_HI;
        ST_RD_HI:   if (out_fire) state <= ST_RD_LO;
        ST_RD_LO: begin
          if (out_fire) begin
            if (last_word) begin
              done_r <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              addr_r <= addr_r + 1'b1;
              cnt_r  <= cnt_r - 1'b1;
              state  <= ST_RD_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_master.sv
// Directed scoreboard bench for ram_stream_master with a behavioural tinycpu RAM.
module tb_ram_stream_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        ram_load;
  logic [11:0] ram_addr;
  logic [15:0] ram_d;
  logic [15:0] ram_q;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [27:0] exp_wr_q[$];

  logic [15:0] mem [0:4095];

  logic        bp_en = 1'b0;
  int          bp_pat[4] = '{1, 0, 0, 1};
  int          bp_idx = 0;

  logic        stalled = 1'b0;
  logic [7:0]  held = 8'h00;

  ram_stream_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .ram_load  (ram_load),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_q     (ram_q),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  end

  // single-port synchronous RAM: write on load, q registered from addr
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // out_ready: always 1, or a repeating 1-0-0-1 pattern when back-pressure is on
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = (bp_pat[bp_idx] != 0);
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_data", {24'b0, out_data}, {24'b0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_byte: got 0x%0h expected none", out_data);
        end else begin
          check("out_byte", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
        end
      end
      if (ram_load) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ram_write: got 0x%0h expected none", {ram_addr, ram_d});
        end else begin
          check("ram_write", {4'b0, ram_addr, ram_d}, {4'b0, exp_wr_q.pop_front()});
        end
      end
      stalled = out_valid && !out_ready;
      held = out_data;
    end
  end

  // driver tasks: each starts and ends just after a posedge
  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [11:0] l);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("in_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin n++; @(negedge clk); end
    check("done_seen", {31'b0, done}, 32'd1);
    check("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ram_load", {31'b0, ram_load}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_ram_addr", {20'b0, ram_addr}, 32'd0);
    check("idle_ram_d", {16'b0, ram_d}, 32'd0);
    @(posedge clk); #1;

    // single write then read back with first-byte latency
    exp_wr_q.push_back({12'h001, 16'h1234});
    send_cmd(1'b1, 12'h001, 12'h000);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_done();

    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    send_cmd(1'b0, 12'h001, 12'h000);
    @(negedge clk); check("lat_rd_addr", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("lat_rd_cap", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("lat_rd_hi", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    wait_done();

    // burst with address wrap
    exp_wr_q.push_back({12'hFFE, 16'hAAAA});
    exp_wr_q.push_back({12'hFFF, 16'hBBBB});
    exp_wr_q.push_back({12'h000, 16'hCCCC});
    send_cmd(1'b1, 12'hFFE, 12'h002);
    send_byte(8'hAA); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hBB);
    send_byte(8'hCC); send_byte(8'hCC);
    wait_done();

    exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hCC);
    send_cmd(1'b0, 12'hFFE, 12'h002);
    wait_done();

    // back-pressure on a two-word read
    @(negedge clk); bp_en = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hBB);
    send_cmd(1'b0, 12'hFFE, 12'h001);
    wait_done();
    @(negedge clk); bp_en = 1'b0;
    @(posedge clk); #1;

    // gapped input bytes
    exp_wr_q.push_back({12'h100, 16'h1122});
    exp_wr_q.push_back({12'h101, 16'h3344});
    send_cmd(1'b1, 12'h100, 12'h001);
    send_byte(8'h11);
    repeat (5) begin @(negedge clk); check("gap_busy", {31'b0, busy}, 32'd1); end
    @(posedge clk); #1;
    send_byte(8'h22);
    repeat (5) begin @(negedge clk); check("gap_busy", {31'b0, busy}, 32'd1); end
    @(posedge clk); #1;
    send_byte(8'h33);
    repeat (5) begin @(negedge clk); check("gap_busy", {31'b0, busy}, 32'd1); end
    @(posedge clk); #1;
    send_byte(8'h44);
    wait_done();

    // reset in WR_LO after the high byte
    send_cmd(1'b1, 12'h010, 12'h000);
    send_byte(8'h56);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_rst_ram_d", {16'b0, ram_d}, 32'd0);
    check("post_rst_ram_addr", {20'b0, ram_addr}, 32'd0);
    @(posedge clk); #1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_cmd(1'b0, 12'h010, 12'h000);
    wait_done();

    // command held while a read burst is running
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_cmd(1'b0, 12'h001, 12'h001);
    cmd_write = 1'b0; cmd_addr = 12'hFFF; cmd_len = 12'h000; cmd_valid = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!done && n < 300) begin
        check("busy_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        n++;
        @(negedge clk);
      end
    end
    check("held_done", {31'b0, done}, 32'd1);
    check("held_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hBB);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("held_accepted_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    wait_done();

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("exp_wr_q_empty", exp_wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
